// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter (level-sensitive send/busy handshake) among
//   NUM_REQ byte sources using round-robin priority.
//
// Ports:
//   CLK100MHZ    system clock
//   CPU_RESETN   asynchronous active-low reset
//   req_valid    per-requester byte-available flags
//   req_data     flattened bytes, requester i on [8i+7:8i]
//   req_ready    one-cycle one-hot pulse: byte of requester i accepted
//   tx_send      send request to the transmitter
//   tx_din       byte to the transmitter, stable from grant to next grant
//   tx_busy      transmitter busy
//   grant_id     index of the current/last granted requester
//   active       high from grant until the transmission completes
//   timeout_err  sticky: transmitter never went busy after a send
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 1000
) (
  input  logic                       CLK100MHZ,
  input  logic                       CPU_RESETN,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_send,
  output logic [7:0]                 tx_din,
  input  logic                       tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       active,
  output logic                       timeout_err
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_DONE
  } state_t;

  state_t             state_q;
  logic [NUM_REQ-1:0] ready_q;
  logic               send_q;
  logic [7:0]         din_q;
  logic [IW-1:0]      gid_q;
  logic               active_q;
  logic               err_q;
  logic [IW-1:0]      ptr_q;
  logic [CW-1:0]      cnt_q;

  logic               win_found_d;
  logic [IW-1:0]      win_idx_d;
  logic [NUM_REQ-1:0] win_oh_d;
  logic [IW-1:0]      cand_d;
  logic [IW-1:0]      next_ptr_d;

  // Search from the priority pointer upward, wrapping; first valid wins.
  always_comb begin
    win_found_d = 1'b0;
    win_idx_d   = '0;
    win_oh_d    = '0;
    cand_d      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand_d = IW'((32'(ptr_q) + i) % NUM_REQ);
      if (!win_found_d && req_valid[cand_d]) begin
        win_found_d = 1'b1;
        win_idx_d   = cand_d;
      end
    end
    win_oh_d[win_idx_d] = 1'b1;
  end

  // Priority moves past whoever was served last, so a busy requester
  // cannot win twice before every other valid requester has had a turn.
  assign next_ptr_d = (gid_q == IW'(NUM_REQ - 1)) ? '0 : gid_q + IW'(1);

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q  <= IDLE;
      ready_q  <= '0;
      send_q   <= 1'b0;
      din_q    <= '0;
      gid_q    <= '0;
      active_q <= 1'b0;
      err_q    <= 1'b0;
      ptr_q    <= '0;
      cnt_q    <= '0;
    end else begin
      ready_q <= '0;
      case (state_q)
        IDLE: begin
          // A transmitter still busy from before reset blocks new grants.
          if (win_found_d && !tx_busy) begin
            din_q    <= req_data[{win_idx_d, 3'b000} +: 8];
            send_q   <= 1'b1;
            ready_q  <= win_oh_d;
            gid_q    <= win_idx_d;
            active_q <= 1'b1;
            cnt_q    <= '0;
            state_q  <= SEND;
          end
        end
        SEND: begin
          if (tx_busy) begin
            send_q  <= 1'b0;
            state_q <= WAIT_DONE;
          end else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
            send_q   <= 1'b0;
            active_q <= 1'b0;
            err_q    <= 1'b1;
            ptr_q    <= next_ptr_d;
            state_q  <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            active_q <= 1'b0;
            ptr_q    <= next_ptr_d;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready   = ready_q;
  assign tx_send     = send_q;
  assign tx_din      = din_q;
  assign grant_id    = gid_q;
  assign active      = active_q;
  assign timeout_err = err_q;

endmodule
